// File: rtl/ifetch_unit_pkg.sv
// Shared constants for the instruction fetch front-end: opcodes the pre-decoder
// recognises, the BHT counter reset value and the fetch FSM state encoding.
package ifetch_unit_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_RISC_B = 7'b1100011;

  // Weakly not-taken: a single taken outcome flips the prediction.
  localparam logic [1:0] BHT_INIT = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD,
    ST_JWAIT
  } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_branch_predictor.sv
// Branch history table of 2-bit saturating counters with one combinational
// read port and one committed-outcome update port.
module branch_predictor
  import ifetch_unit_pkg::*;
#(
  parameter int BHT_IDX_W = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic                 rd_taken,
  input  logic                 upd_valid,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  localparam int ENTRIES = 1 << BHT_IDX_W;

  logic [1:0] bht [ENTRIES];

  // Read is combinational off the array, so an update on the same edge is not yet visible.
  assign rd_taken = bht[rd_idx][1];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= BHT_INIT;
      end
    end else if (rdy_in && upd_valid) begin
      if (upd_taken) begin
        if (bht[upd_idx] != 2'b11) begin
          bht[upd_idx] <= bht[upd_idx] + 2'd1;
        end
      end else if (bht[upd_idx] != 2'b00) begin
        bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from the i-cache, predicts
// the next PC for JAL/B/JALR and hands one instruction at a time to the decoder.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int          BHT_IDX_W = 6,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_ins,
  output logic        dec_ins_ready,
  output logic [31:0] dec_ins,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_predict_nxt_pc,
  input  logic        dec_stall,
  input  logic        dec_clear,
  input  logic [31:0] dec_new_addr,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_addr,
  input  logic        rob_br_valid,
  input  logic [31:0] rob_br_pc,
  input  logic        rob_br_taken
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic         discard, discard_n;
  logic         req_valid_n;
  logic [31:0]  req_addr_n;
  logic         ins_ready_n;
  logic [31:0]  ins_n, dpc_n, dnxt_n;

  logic [31:0]  imm_j, imm_b, nxt_pc, redirect_pc;
  logic         is_jal, is_b, bp_taken, pred_taken, redirect, accepted;
  logic         unused_addr_bits;

  branch_predictor #(
    .BHT_IDX_W(BHT_IDX_W)
  ) u_bp (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .rd_idx   (pc[BHT_IDX_W+1:2]),
    .rd_taken (bp_taken),
    .upd_valid(rob_br_valid),
    .upd_idx  (rob_br_pc[BHT_IDX_W+1:2]),
    .upd_taken(rob_br_taken)
  );

  assign unused_addr_bits = ^{pc[0], rob_br_pc[31:BHT_IDX_W+2], rob_br_pc[1:0]};

  // Pre-decode of the word arriving from the i-cache; pc still names that word in WAIT.
  assign is_jal     = (icache_resp_ins[6:0] == OPC_JAL);
  assign is_b       = (icache_resp_ins[6:0] == OPC_RISC_B);
  assign imm_j      = {{11{icache_resp_ins[31]}}, icache_resp_ins[31], icache_resp_ins[19:12],
                       icache_resp_ins[20], icache_resp_ins[30:21], 1'b0};
  assign imm_b      = {{19{icache_resp_ins[31]}}, icache_resp_ins[31], icache_resp_ins[7],
                       icache_resp_ins[30:25], icache_resp_ins[11:8], 1'b0};
  assign pred_taken = is_b && bp_taken;
  assign nxt_pc     = is_jal ? pc + imm_j : (pred_taken ? pc + imm_b : pc + 32'd4);

  assign redirect    = rob_flush || dec_clear;
  assign redirect_pc = rob_flush ? rob_flush_addr : dec_new_addr;
  assign accepted    = dec_ins_ready && !dec_stall;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    discard_n   = discard;
    req_valid_n = icache_req_valid;
    req_addr_n  = icache_req_addr;
    ins_ready_n = dec_ins_ready;
    ins_n       = dec_ins;
    dpc_n       = dec_pc;
    dnxt_n      = dec_predict_nxt_pc;

    unique case (state)
      ST_IDLE: begin
        if (redirect) begin
          pc_n        = redirect_pc;
          ins_ready_n = 1'b0;
        end else begin
          req_valid_n = 1'b1;
          req_addr_n  = pc;
          state_n     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The outstanding request always runs to completion; a redirect only marks it stale.
        if (redirect) begin
          pc_n        = redirect_pc;
          ins_ready_n = 1'b0;
          if (icache_resp_valid) begin
            req_valid_n = 1'b0;
            discard_n   = 1'b0;
            state_n     = ST_IDLE;
          end else begin
            discard_n = 1'b1;
          end
        end else if (icache_resp_valid) begin
          req_valid_n = 1'b0;
          if (discard) begin
            discard_n = 1'b0;
            state_n   = ST_IDLE;
          end else begin
            ins_n       = icache_resp_ins;
            ins_ready_n = 1'b1;
            dpc_n       = {pc[31:1], pred_taken};
            dnxt_n      = nxt_pc;
            state_n     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_n        = redirect_pc;
          ins_ready_n = 1'b0;
          state_n     = ST_IDLE;
        end else if (accepted) begin
          ins_ready_n = 1'b0;
          pc_n        = dec_predict_nxt_pc;
          state_n     = (dec_ins[6:0] == OPC_JALR) ? ST_JWAIT : ST_IDLE;
        end
      end
      ST_JWAIT: begin
        if (redirect) begin
          pc_n        = redirect_pc;
          ins_ready_n = 1'b0;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= ST_IDLE;
      pc                 <= RESET_PC;
      discard            <= 1'b0;
      icache_req_valid   <= 1'b0;
      icache_req_addr    <= 32'h0;
      dec_ins_ready      <= 1'b0;
      dec_ins            <= 32'h0;
      dec_pc             <= 32'h0;
      dec_predict_nxt_pc <= 32'h0;
    end else if (rdy_in) begin
      state              <= state_n;
      pc                 <= pc_n;
      discard            <= discard_n;
      icache_req_valid   <= req_valid_n;
      icache_req_addr    <= req_addr_n;
      dec_ins_ready      <= ins_ready_n;
      dec_ins            <= ins_n;
      dec_pc             <= dpc_n;
      dec_predict_nxt_pc <= dnxt_n;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios followed by a randomized program run
// checked against a transaction-level model of the fetched instruction stream.
module tb_ifetch_unit;

  logic        clk_in, rst_in, rdy_in;
  logic        icache_req_valid, icache_resp_valid;
  logic [31:0] icache_req_addr, icache_resp_ins;
  logic        dec_ins_ready, dec_stall, dec_clear;
  logic [31:0] dec_ins, dec_pc, dec_predict_nxt_pc, dec_new_addr;
  logic        rob_flush, rob_br_valid, rob_br_taken;
  logic [31:0] rob_flush_addr, rob_br_pc;

  ifetch_unit dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .icache_req_valid  (icache_req_valid),
    .icache_req_addr   (icache_req_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_ins   (icache_resp_ins),
    .dec_ins_ready     (dec_ins_ready),
    .dec_ins           (dec_ins),
    .dec_pc            (dec_pc),
    .dec_predict_nxt_pc(dec_predict_nxt_pc),
    .dec_stall         (dec_stall),
    .dec_clear         (dec_clear),
    .dec_new_addr      (dec_new_addr),
    .rob_flush         (rob_flush),
    .rob_flush_addr    (rob_flush_addr),
    .rob_br_valid      (rob_br_valid),
    .rob_br_pc         (rob_br_pc),
    .rob_br_taken      (rob_br_taken)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Program image (1 KB, aliased) with per-word kind (0 alu, 1 jal, 2 branch, 3 jalr) and offset.
  logic [31:0] prog_word [256];
  int          prog_kind [256];
  int          prog_off  [256];
  int          bht_model [64];

  int checks, failures, cyc;
  int lat, cur_lat, cnt;
  bit rand_lat;

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic logic [31:0] enc(input int kind, input int off);
    logic [31:0] o;
    o = off;
    case (kind)
      1:       enc = {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
      2:       enc = {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
      3:       enc = {12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111};
      default: enc = {12'd1, 5'd5, 3'b000, 5'd5, 7'b0010011};
    endcase
  endfunction

  task automatic setWord(input logic [31:0] addr, input int kind, input int off);
    prog_word[widx(addr)] = enc(kind, off);
    prog_kind[widx(addr)] = kind;
    prog_off[widx(addr)]  = off;
  endtask

  // Expected next PC and taken flag, from the program table and the model BHT.
  task automatic modelPredict(input logic [31:0] pc, output logic taken, output logic [31:0] nxt);
    int k;
    k     = prog_kind[widx(pc)];
    taken = (k == 2) && (bht_model[int'(pc[7:2])] >= 2);
    if (k == 1 || taken) nxt = pc + 32'(prog_off[widx(pc)]);
    else                 nxt = pc + 32'd4;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // I-cache responder: answers cur_lat cycles into a request; frozen while rdy_in is low.
  task automatic cacheStep();
    if (rst_in) begin
      icache_resp_valid = 1'b0;
      cnt = 0;
      return;
    end
    if (!rdy_in) return;
    icache_resp_valid = 1'b0;
    if (icache_req_valid) begin
      if (cnt == 0) cur_lat = rand_lat ? $urandom_range(1, 3) : lat;
      cnt++;
      if (cnt >= cur_lat) begin
        icache_resp_valid = 1'b1;
        icache_resp_ins   = prog_word[widx(icache_req_addr)];
        cnt = 0;
      end
    end else begin
      cnt = 0;
    end
  endtask

  task automatic clockEdge();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus();
    cacheStep();
    clockEdge();
  endtask

  task automatic waitReady(input string tag, input int max);
    int n = 0;
    while (!dec_ins_ready && n < max) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_ready"}, 32'(dec_ins_ready), 32'd1);
  endtask

  task automatic waitReq(input string tag, input int max);
    int n = 0;
    while (!icache_req_valid && n < max) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_req"}, 32'(icache_req_valid), 32'd1);
  endtask

  task automatic doFlush(input logic [31:0] addr);
    rob_flush      = 1'b1;
    rob_flush_addr = addr;
    applyStimulus();
    rob_flush = 1'b0;
  endtask

  task automatic doReset();
    rst_in = 1'b1;
    applyStimulus();
    applyStimulus();
    rst_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    logic        saw_req, exp_taken, waiting_clear;
    logic [31:0] exp_nxt, model_pc, prev;
    int          jw_cnt, jw_wait, accepted, idle;

    checks = 0; failures = 0; cyc = 0; cnt = 0; lat = 1; cur_lat = 1; rand_lat = 0;
    rst_in = 1'b1; rdy_in = 1'b1;
    icache_resp_valid = 1'b0; icache_resp_ins = 32'h0;
    dec_stall = 1'b0; dec_clear = 1'b0; dec_new_addr = 32'h0;
    rob_flush = 1'b0; rob_flush_addr = 32'h0;
    rob_br_valid = 1'b0; rob_br_pc = 32'h0; rob_br_taken = 1'b0;
    for (int i = 0; i < 256; i++) setWord(32'(i * 4), 0, 0);
    setWord(32'h10, 1, 16);
    setWord(32'h40, 2, -8);
    setWord(32'h48, 2, 12);
    setWord(32'h80, 3, 0);

    #1;
    checkOutput("rst_req_valid", 32'(icache_req_valid), 32'd0);
    checkOutput("rst_ready", 32'(dec_ins_ready), 32'd0);
    checkOutput("rst_dec_pc", dec_pc, 32'h0);
    checkOutput("rst_nxt", dec_predict_nxt_pc, 32'h0);
    doReset();

    $display("[TB] straight-line fetch");
    waitReq("t1", 5);
    checkOutput("t1_addr0", icache_req_addr, 32'h0);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      waitReady("t1", 10);
      checkOutput("t1_pc", dec_pc, 32'(4 * k));
      checkOutput("t1_nxt", dec_predict_nxt_pc, 32'(4 * k + 4));
      checkOutput("t1_ins", dec_ins, 32'h00128293);
      if (k > 0) checkOutput("t1_gap", 32'(cyc) - prev, 32'd3);
      prev = 32'(cyc);
      if (k < 2) applyStimulus();
    end

    $display("[TB] JAL prediction");
    doFlush(32'h10);
    waitReady("t2", 10);
    checkOutput("t2_pc", dec_pc, 32'h10);
    checkOutput("t2_ins", dec_ins, 32'h010000EF);
    checkOutput("t2_nxt", dec_predict_nxt_pc, 32'h20);
    applyStimulus();
    waitReq("t2", 5);
    checkOutput("t2_addr", icache_req_addr, 32'h20);

    $display("[TB] branch predicted taken then flushed");
    rob_br_valid = 1'b1; rob_br_pc = 32'h40; rob_br_taken = 1'b1;
    repeat (3) applyStimulus();
    rob_br_valid = 1'b0;
    doFlush(32'h40);
    waitReady("t3", 10);
    checkOutput("t3_pc", dec_pc, 32'h41);
    checkOutput("t3_ins", dec_ins, 32'hFE208CE3);
    checkOutput("t3_nxt", dec_predict_nxt_pc, 32'h38);
    doFlush(32'h44);
    checkOutput("t3_flush_ready", 32'(dec_ins_ready), 32'd0);
    waitReady("t3b", 10);
    checkOutput("t3_pc_after", dec_pc, 32'h44);
    checkOutput("t3_nxt_after", dec_predict_nxt_pc, 32'h48);

    $display("[TB] BHT update in the lookup cycle");
    doFlush(32'h48);
    waitReq("t3c", 5);
    rob_br_valid = 1'b1; rob_br_pc = 32'h48; rob_br_taken = 1'b1;
    applyStimulus();
    rob_br_valid = 1'b0;
    checkOutput("t3c_ready", 32'(dec_ins_ready), 32'd1);
    checkOutput("t3c_pc_old", dec_pc, 32'h48);
    checkOutput("t3c_nxt_old", dec_predict_nxt_pc, 32'h4C);
    doFlush(32'h48);
    waitReady("t3d", 10);
    checkOutput("t3d_pc_new", dec_pc, 32'h49);
    checkOutput("t3d_nxt_new", dec_predict_nxt_pc, 32'h54);

    $display("[TB] JALR stops fetch until dec_clear");
    doFlush(32'h80);
    waitReady("t4", 10);
    checkOutput("t4_pc", dec_pc, 32'h80);
    checkOutput("t4_nxt", dec_predict_nxt_pc, 32'h84);
    applyStimulus();
    saw_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      saw_req |= icache_req_valid;
    end
    checkOutput("t4_no_req", 32'(saw_req), 32'd0);
    checkOutput("t4_not_ready", 32'(dec_ins_ready), 32'd0);
    dec_clear = 1'b1; dec_new_addr = 32'h200;
    applyStimulus();
    dec_clear = 1'b0;
    waitReq("t4", 5);
    checkOutput("t4_addr", icache_req_addr, 32'h200);

    $display("[TB] flush while waiting on a slow cache");
    doFlush(32'h60);
    lat = 4;
    waitReq("t5", 5);
    checkOutput("t5_addr", icache_req_addr, 32'h60);
    doFlush(32'h100);
    saw_req = 1'b0;
    for (int i = 0; i < 10 && icache_req_valid; i++) begin
      saw_req |= dec_ins_ready;
      checkOutput("t5_addr_held", icache_req_addr, 32'h60);
      applyStimulus();
    end
    checkOutput("t5_req_done", 32'(icache_req_valid), 32'd0);
    checkOutput("t5_stale_dropped", 32'(saw_req | dec_ins_ready), 32'd0);
    lat = 1;
    waitReq("t5b", 5);
    checkOutput("t5_new_addr", icache_req_addr, 32'h100);
    waitReady("t5", 10);
    checkOutput("t5_pc", dec_pc, 32'h100);

    $display("[TB] stall, rdy_in freeze and asynchronous reset");
    dec_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("t6_stall_ready", 32'(dec_ins_ready), 32'd1);
      checkOutput("t6_stall_pc", dec_pc, 32'h100);
      checkOutput("t6_stall_nxt", dec_predict_nxt_pc, 32'h104);
    end
    dec_stall = 1'b0; rdy_in = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("t6_frozen_ready", 32'(dec_ins_ready), 32'd1);
    checkOutput("t6_frozen_pc", dec_pc, 32'h100);
    rdy_in = 1'b1;
    applyStimulus();
    checkOutput("t6_accepted", 32'(dec_ins_ready), 32'd0);
    waitReq("t6", 5);
    checkOutput("t6_addr", icache_req_addr, 32'h104);
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("t6_async_req", 32'(icache_req_valid), 32'd0);
    checkOutput("t6_async_addr", icache_req_addr, 32'h0);
    checkOutput("t6_async_pc", dec_pc, 32'h0);
    applyStimulus();
    rst_in = 1'b0;
    waitReq("t6b", 5);
    checkOutput("t6_reset_pc", icache_req_addr, 32'h0);

    $display("[TB] randomized program run");
    for (int i = 0; i < 256; i++) begin
      int r, off;
      r   = $urandom_range(0, 9);
      off = ($urandom_range(0, 16) - 8) * 4;
      if (r == 5 || r == 6) setWord(32'(i * 4), 2, off);
      else if (r == 7)      setWord(32'(i * 4), 1, off);
      else if (r == 8)      setWord(32'(i * 4), 3, 0);
      else                  setWord(32'(i * 4), 0, 0);
    end
    for (int i = 0; i < 64; i++) bht_model[i] = 1;
    rand_lat = 1;
    doReset();
    model_pc = 32'h0; waiting_clear = 1'b0; saw_req = 1'b0;
    jw_cnt = 0; jw_wait = 1; accepted = 0; idle = 0;

    for (int c = 0; c < 2500; c++) begin
      if (waiting_clear && icache_req_valid) saw_req = 1'b1;
      if (dec_ins_ready) begin
        modelPredict(model_pc, exp_taken, exp_nxt);
        checkOutput("rnd_pc", dec_pc, model_pc | 32'(exp_taken));
        checkOutput("rnd_nxt", dec_predict_nxt_pc, exp_nxt);
        checkOutput("rnd_ins", dec_ins, prog_word[widx(model_pc)]);
      end
      idle = (dec_ins_ready || waiting_clear) ? 0 : idle + 1;
      if (idle > 40) begin
        checkOutput("rnd_progress_stall", 32'(idle), 32'd0);
        break;
      end

      cacheStep();
      dec_stall = ($urandom_range(0, 3) == 0);
      rob_flush = 1'b0; dec_clear = 1'b0; rob_br_valid = 1'b0;
      if (waiting_clear) begin
        jw_cnt++;
        if (jw_cnt >= jw_wait) begin
          checkOutput("rnd_jwait_noreq", 32'(saw_req), 32'd0);
          dec_clear    = 1'b1;
          dec_new_addr = {22'h0, 8'($urandom), 2'b00};
          if ($urandom_range(0, 2) == 0) begin
            rob_flush      = 1'b1;
            rob_flush_addr = {22'h0, 8'($urandom), 2'b00};
          end
        end
      end else if ($urandom_range(0, 39) == 0) begin
        rob_flush      = 1'b1;
        rob_flush_addr = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                                     : {22'h0, 8'($urandom), 2'b00};
      end
      // BHT updates avoid the capture-to-accept window so the model's lookup time is unambiguous.
      if (!icache_resp_valid && !dec_ins_ready && $urandom_range(0, 3) == 0) begin
        int bi;
        rob_br_valid = 1'b1;
        rob_br_pc    = {22'h0, 8'($urandom), 2'b00};
        rob_br_taken = 1'($urandom);
        bi = int'(rob_br_pc[7:2]);
        if (rob_br_taken) bht_model[bi] = (bht_model[bi] == 3) ? 3 : bht_model[bi] + 1;
        else              bht_model[bi] = (bht_model[bi] == 0) ? 0 : bht_model[bi] - 1;
      end

      if (rob_flush || dec_clear) begin
        model_pc      = rob_flush ? rob_flush_addr : dec_new_addr;
        waiting_clear = 1'b0;
      end else if (dec_ins_ready && !dec_stall) begin
        modelPredict(model_pc, exp_taken, exp_nxt);
        accepted++;
        if (prog_kind[widx(model_pc)] == 3) begin
          waiting_clear = 1'b1;
          saw_req = 1'b0;
          jw_cnt  = 0;
          jw_wait = $urandom_range(1, 6);
        end
        model_pc = exp_nxt;
      end
      clockEdge();
    end
    rob_flush = 1'b0; dec_clear = 1'b0; rob_br_valid = 1'b0; dec_stall = 1'b0;
    checkOutput("rnd_accepted_enough", 32'(accepted > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
